// File: rtl/digit_entry_buffer.sv
// digit_entry_buffer: keypad BCD digit-entry register with backspace, clear, commit and overflow.
// Sign-key support is compiled in when DIGIT_ENTRY_SIGN_EN is defined.
module digit_entry_buffer #(
  parameter int DIGITS = 4,
  parameter int CW     = $clog2(DIGITS + 1)
) (
  input  logic                CLK100MHZ,
  input  logic                reset,
  input  logic                key_valid,
  input  logic [3:0]          key_code,
  output logic [4*DIGITS-1:0] entry,
  output logic [CW-1:0]       count,
  output logic                full,
  output logic                entry_neg,
  output logic [4*DIGITS-1:0] value,
  output logic                value_neg,
  output logic                commit,
  output logic                overflow
);
  localparam int EW = 4 * DIGITS;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIGITS);

  logic          key_valid_q;
  logic          key_event;
  logic          is_digit;
  logic [EW+3:0] shifted;

  assign key_event = key_valid & ~key_valid_q;
  assign is_digit  = (key_code <= 4'd9);
  // Concatenate then truncate so the oldest nibble drops off; also works for DIGITS == 1.
  assign shifted   = {entry, key_code};
  assign full      = (count == CNT_MAX);

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      key_valid_q <= 1'b0;
      entry       <= '0;
      count       <= '0;
      value       <= '0;
      commit      <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      key_valid_q <= key_valid;
      commit      <= 1'b0;
      overflow    <= 1'b0;
      if (key_event) begin
        if (is_digit) begin
          if (!full) begin
            entry <= shifted[EW-1:0];
            count <= count + CW'(1);
          end else begin
            overflow <= 1'b1;
          end
        end else begin
          case (key_code)
            4'hD: begin
              if (count != '0) begin
                entry <= entry >> 4;
                count <= count - CW'(1);
              end
            end
            4'hC: begin
              entry <= '0;
              count <= '0;
            end
            4'hE: begin
              value  <= entry;
              commit <= 1'b1;
              entry  <= '0;
              count  <= '0;
            end
            default: ;
          endcase
        end
      end
    end
  end

`ifdef DIGIT_ENTRY_SIGN_EN
  // Sign may be toggled at any digit count, including before the first digit.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      entry_neg <= 1'b0;
      value_neg <= 1'b0;
    end else if (key_event) begin
      case (key_code)
        4'hB: entry_neg <= ~entry_neg;
        4'hC: entry_neg <= 1'b0;
        4'hE: begin
          value_neg <= entry_neg;
          entry_neg <= 1'b0;
        end
        default: ;
      endcase
    end
  end
`else
  assign entry_neg = 1'b0;
  assign value_neg = 1'b0;
`endif

endmodule
